// File: rtl/bb_addr_xlate.sv
// rtl/bb_addr_xlate.sv - bridge-to-bus address translator with per-slave relocation
// Splits the bridge address into slave select and local offset, relocates it, and queues it in a 2-entry buffer.
module bb_addr_xlate #(
  parameter int BB_ADDR_WIDTH      = 13,
  parameter int BUS_ADDR_WIDTH     = 16,
  parameter int BUS_MEM_ADDR_WIDTH = 12,
  parameter int NUM_SLAVES         = 3,
  parameter int WRAP_EN            = 0,
  parameter int ERR_CNT_WIDTH      = 8,
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  localparam int LOC_W = BB_ADDR_WIDTH - SEL_W
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BB_ADDR_WIDTH-1:0]      in_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BUS_ADDR_WIDTH-1:0]     out_addr,
  output logic                          out_err,
  input  logic                          cfg_wr,
  input  logic [SEL_W-1:0]              cfg_slave,
  input  logic [BUS_MEM_ADDR_WIDTH-1:0] cfg_offset,
  input  logic                          cfg_en,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt
);

  localparam int MW = BUS_MEM_ADDR_WIDTH;

  logic [MW-1:0]         off_tab [NUM_SLAVES];
  logic [NUM_SLAVES-1:0] en_tab;

  logic [SEL_W-1:0] slave;
  logic [LOC_W-1:0] loc;
  logic [MW-1:0]    sel_off;
  logic             sel_en;
  logic             hit;
  logic [MW:0]      sum;
  logic [BUS_ADDR_WIDTH-1:0] new_addr;
  logic             new_err;

  assign slave = in_addr[BB_ADDR_WIDTH-1 -: SEL_W];
  assign loc   = in_addr[LOC_W-1:0];

  // Out-of-range selects find no entry, so they relocate by 0 and read as disabled.
  always_comb begin
    sel_off = '0;
    sel_en  = 1'b0;
    hit     = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slave == SEL_W'(i)) begin
        sel_off = off_tab[i];
        sel_en  = en_tab[i];
        hit     = 1'b1;
      end
    end
  end

  assign sum      = (MW+1)'(loc) + (MW+1)'(sel_off);
  assign new_addr = BUS_ADDR_WIDTH'({slave, sum[MW-1:0]});
  assign new_err  = ~hit | ~sel_en | (sum[MW] & (WRAP_EN == 0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_SLAVES; i++) off_tab[i] <= '0;
      en_tab <= '1;
    end else if (cfg_wr) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (cfg_slave == SEL_W'(i)) begin
          off_tab[i] <= cfg_offset;
          en_tab[i]  <= cfg_en;
        end
      end
    end
  end

  // Head register drives the outputs directly; tail only fills when the head is stalled.
  logic [1:0]                count;
  logic [BUS_ADDR_WIDTH-1:0] head_addr, tail_addr;
  logic                      head_err, tail_err;
  logic                      push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_addr  = head_addr;
  assign out_err   = head_err;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count     <= 2'd0;
      head_addr <= '0;
      head_err  <= 1'b0;
      tail_addr <= '0;
      tail_err  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_addr <= new_addr;
            head_err  <= new_err;
            count     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_addr <= new_addr;
            head_err  <= new_err;
          end else if (push) begin
            tail_addr <= new_addr;
            tail_err  <= new_err;
            count     <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_addr <= tail_addr;
            head_err  <= tail_err;
            count     <= 2'd1;
          end
        end
      endcase
      if (pop && head_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_bb_addr_xlate.sv
// tb/tb_bb_addr_xlate.sv - self-checking bench for bb_addr_xlate
// Drives a default instance and a wrapping instance in lockstep against a queue-based reference model.
module tb_bb_addr_xlate;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [12:0] in_addr = '0;
  logic        out_ready = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_slave = '0;
  logic [11:0] cfg_offset = '0;
  logic        cfg_en = 1'b0;

  logic        in_ready0, in_ready1, out_valid0, out_valid1, out_err0, out_err1;
  logic [15:0] out_addr0, out_addr1;
  logic [7:0]  err_cnt0, err_cnt1;

  always #5 clk = ~clk;

  bb_addr_xlate #(.WRAP_EN(0)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready0), .in_addr(in_addr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_addr(out_addr0), .out_err(out_err0),
    .cfg_wr(cfg_wr), .cfg_slave(cfg_slave), .cfg_offset(cfg_offset), .cfg_en(cfg_en),
    .err_cnt(err_cnt0));

  bb_addr_xlate #(.WRAP_EN(1)) dut_wrap (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready1), .in_addr(in_addr),
    .out_valid(out_valid1), .out_ready(out_ready), .out_addr(out_addr1), .out_err(out_err1),
    .cfg_wr(cfg_wr), .cfg_slave(cfg_slave), .cfg_offset(cfg_offset), .cfg_en(cfg_en),
    .err_cnt(err_cnt1));

  typedef struct {
    int addr;
    bit e0;
    bit e1;
  } ent_t;

  int   checks = 0;
  int   failures = 0;
  ent_t q[$];
  ent_t last;
  int   ecnt0, ecnt1;
  int   m_off[3];
  bit   m_en[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t xlate(input int a);
    ent_t r;
    int s, l, off, sum;
    bit en;
    s = a / 2048;
    l = a % 2048;
    off = 0;
    en = 1'b0;
    if (s < 3) begin
      off = m_off[s];
      en  = m_en[s];
    end
    sum  = l + off;
    r.addr = s * 4096 + sum % 4096;
    r.e1   = (s >= 3) || !en;
    r.e0   = r.e1 || (sum >= 4096);
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    last.addr = 0;
    last.e0 = 1'b0;
    last.e1 = 1'b0;
    ecnt0 = 0;
    ecnt1 = 0;
    for (int i = 0; i < 3; i++) begin
      m_off[i] = 0;
      m_en[i]  = 1'b1;
    end
  endtask

  // Check outputs mid-cycle, then advance one clock and update the model from the pre-edge state.
  task automatic step();
    ent_t h, n;
    bit pu, po;
    h = (q.size() > 0) ? q[0] : last;
    chk("in_ready", in_ready0, q.size() < 2);
    chk("in_ready_wrap", in_ready1, q.size() < 2);
    chk("out_valid", out_valid0, q.size() > 0);
    chk("out_valid_wrap", out_valid1, q.size() > 0);
    chk("out_addr", out_addr0, h.addr);
    chk("out_addr_wrap", out_addr1, h.addr);
    chk("out_err", out_err0, h.e0);
    chk("out_err_wrap", out_err1, h.e1);
    chk("err_cnt", err_cnt0, ecnt0);
    chk("err_cnt_wrap", err_cnt1, ecnt1);
    @(posedge clk);
    pu = in_valid && (q.size() < 2);
    po = out_ready && (q.size() > 0);
    n = xlate(int'(in_addr));
    if (po) begin
      last = q.pop_front();
      if (last.e0 && ecnt0 < 255) ecnt0++;
      if (last.e1 && ecnt1 < 255) ecnt1++;
    end
    if (pu) q.push_back(n);
    if (cfg_wr && cfg_slave < 2'd3) begin
      m_off[cfg_slave] = int'(cfg_offset);
      m_en[cfg_slave]  = cfg_en;
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [12:0] a, input bit r);
    in_valid  = v;
    in_addr   = a;
    out_ready = r;
  endtask

  task automatic cfg(input bit w, input logic [1:0] s, input logic [11:0] o, input bit e);
    cfg_wr     = w;
    cfg_slave  = s;
    cfg_offset = o;
    cfg_en     = e;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_out_addr", out_addr0, 16'h0000);
    rstn = 1'b1;

    // Default mapping
    drive(1, 13'h0805, 1); step();
    chk("tp_default_addr", out_addr0, 16'h1005);
    chk("tp_default_err", out_err0, 1'b0);
    drive(0, 13'h0000, 1); step();

    // Out-of-range slave
    drive(1, 13'h1FFF, 1); step();
    chk("tp_range_addr", out_addr0, 16'h37FF);
    chk("tp_range_err", out_err0, 1'b1);
    drive(0, 13'h0000, 1); step();
    chk("tp_range_cnt", err_cnt0, 8'd1);

    // Relocation and overflow
    cfg(1, 2'd0, 12'h100, 1); step(); cfg(0, 2'd0, 12'h000, 0);
    drive(1, 13'h07FF, 1); step();
    chk("tp_offset_addr", out_addr0, 16'h08FF);
    chk("tp_offset_err", out_err0, 1'b0);
    drive(0, 13'h0000, 1);
    cfg(1, 2'd0, 12'hF00, 1); step(); cfg(0, 2'd0, 12'h000, 0);
    drive(1, 13'h0200, 1); step();
    chk("tp_ovf_addr", out_addr0, 16'h0100);
    chk("tp_ovf_err", out_err0, 1'b1);
    chk("tp_wrap_err", out_err1, 1'b0);
    drive(0, 13'h0000, 1);
    cfg(1, 2'd0, 12'h000, 1); step(); cfg(0, 2'd0, 12'h000, 0);

    // Disable with a same-edge accept
    cfg(1, 2'd2, 12'h000, 0); drive(1, 13'h1000, 1); step(); cfg(0, 2'd0, 12'h000, 0);
    chk("tp_same_edge_old", out_err0, 1'b0);
    step();
    chk("tp_disabled_err", out_err0, 1'b1);
    drive(0, 13'h0000, 1);
    cfg(1, 2'd2, 12'h000, 1); step(); cfg(0, 2'd0, 12'h000, 0);

    // Backpressure
    drive(1, 13'h0001, 0); step();
    drive(1, 13'h0802, 0); step();
    chk("tp_bp_full", in_ready0, 1'b0);
    drive(1, 13'h1003, 0); step();
    chk("tp_bp_stable", out_addr0, 16'h0001);
    drive(0, 13'h0000, 1); step();
    chk("tp_bp_second", out_addr0, 16'h1002);
    step();
    step();
    chk("tp_bp_drained", out_valid0, 1'b0);

    // Reset mid-stream
    for (int i = 0; i < 20 && ecnt0 < 5; i++) begin
      drive(1, 13'h1800 + 13'(i), 1); step();
    end
    drive(1, 13'h0811, 0); step();
    drive(0, 13'h0000, 0);
    cfg(1, 2'd1, 12'h123, 1); step(); cfg(0, 2'd0, 12'h000, 0);
    chk("pre_reset_cnt", err_cnt0, 8'd5);
    chk("pre_reset_full", in_ready0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid0, 1'b0);
    chk("mid_rst_in_ready", in_ready0, 1'b1);
    chk("mid_rst_err_cnt", err_cnt0, 8'd0);
    chk("mid_rst_err_cnt_wrap", err_cnt1, 8'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
    drive(0, 13'h0000, 1); step();
    drive(1, 13'h0805, 1); step();
    chk("post_rst_offset", out_addr0, 16'h1005);
    drive(0, 13'h0000, 1); step();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, 13'($urandom_range(0, 8191)), $urandom_range(0, 3) != 0);
      cfg($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)),
          $urandom_range(0, 4) != 0);
      step();
    end
    drive(0, 13'h0000, 1);
    cfg(0, 2'd0, 12'h000, 0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
